// File: rtl/finalsoc_keys_irq_pio_if.sv
// ============================================================================
// Module   : finalsoc_keys_irq_pio_if
// Brief    : Avalon-MM slave bus bundle for the keys/switches input PIO.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface finalsoc_keys_irq_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/finalsoc_keys_irq_pio.sv
// ============================================================================
// Module   : finalsoc_keys_irq_pio
// Brief    : Debounced pushbutton/switch input PIO with sticky edge capture
//            and level interrupt on an Avalon-MM slave port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module finalsoc_keys_irq_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  finalsoc_keys_irq_pio_if.slave bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  localparam int                 c_CNT_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST     = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
  localparam logic [1:0]         c_ADDR_DATA    = 2'd0;
  localparam logic [1:0]         c_ADDR_MASK    = 2'd2;
  localparam logic [1:0]         c_ADDR_CAPTURE = 2'd3;

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync2;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_samp;
  logic [WIDTH-1:0]   r_deb;
  logic [WIDTH-1:0]   r_deb_d;
  logic               r_primed;
  logic [WIDTH-1:0]   r_mask;
  logic [WIDTH-1:0]   r_capture;

  logic               w_tick;
  logic               w_write;
  logic [WIDTH-1:0]   w_agree;
  logic [WIDTH-1:0]   w_deb_next;
  logic [WIDTH-1:0]   w_edge;
  logic [WIDTH-1:0]   w_clear;
  logic [31:0]        w_rdata;

  assign w_tick  = (r_cnt == c_CNT_LAST);
  assign w_write = bus.chipselect && !bus.write_n;

  // A bit only moves when two consecutive tick samples agree.
  assign w_agree    = ~(r_sync2 ^ r_samp);
  assign w_deb_next = (r_sync2 & w_agree) | (r_deb & ~w_agree);

  assign w_clear = (w_write && (bus.address == c_ADDR_CAPTURE)) ? bus.writedata[WIDTH-1:0]
                                                                 : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  // The first tick after reset adopts the synchronized levels as-is so that
  // buttons already held at power-up do not report a spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_samp   <= '1;
      r_deb    <= '1;
      r_primed <= 1'b0;
    end else if (w_tick) begin
      r_samp <= r_sync2;
      if (!r_primed) begin
        r_deb    <= r_sync2;
        r_primed <= 1'b1;
      end else begin
        r_deb <= w_deb_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb_d <= '1;
    end else if (w_tick && !r_primed) begin
      r_deb_d <= r_sync2;
    end else if (r_primed) begin
      r_deb_d <= r_deb;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign w_edge = r_deb & ~r_deb_d;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign w_edge = ~r_deb & r_deb_d;
    end else begin : g_edge_any
      assign w_edge = r_deb ^ r_deb_d;
    end
  endgenerate

  // New edges are OR-ed in after the clear so a colliding edge survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_capture <= '0;
    end else begin
      r_capture <= (r_capture & ~w_clear) | w_edge;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_write && (bus.address == c_ADDR_MASK)) begin
      r_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      c_ADDR_DATA:    w_rdata[WIDTH-1:0] = r_deb;
      c_ADDR_MASK:    w_rdata[WIDTH-1:0] = r_mask;
      c_ADDR_CAPTURE: w_rdata[WIDTH-1:0] = r_capture;
      default:        w_rdata = '0;
    endcase
  end

  assign bus.readdata = w_rdata;
  assign irq          = |(r_capture & r_mask);

  generate
    if (WIDTH < 32) begin : g_wdata_upper
      logic w_unused_wdata;
      assign w_unused_wdata = ^bus.writedata[31:WIDTH];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_finalsoc_keys_irq_pio.sv
// ============================================================================
// Module   : tb_finalsoc_keys_irq_pio
// Brief    : Directed + random bench for the keys PIO against a tick-level
//            reference model (falling-edge and any-edge instances side by side).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_finalsoc_keys_irq_pio;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] keys;
  logic       irq1;
  logic       irq2;

  finalsoc_keys_irq_pio_if bus1 ();
  finalsoc_keys_irq_pio_if bus2 ();

  finalsoc_keys_irq_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(keys), .irq(irq1));

  finalsoc_keys_irq_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(keys), .irq(irq2));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: debounced levels sampled every 4th edge from the input
  // as it was two edges earlier; capture bits land one edge after a change.
  logic [3:0] m_deb, m_samp, m_mask, m_cap1, m_cap2, m_pend1, m_pend2;
  bit         m_primed;
  int         ecount;
  logic [3:0] hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a, input logic [3:0] cap);
    case (a)
      2'd0:    return {28'b0, m_deb};
      2'd2:    return {28'b0, m_mask};
      2'd3:    return {28'b0, cap};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_deb = 4'hF; m_samp = 4'hF; m_mask = 4'h0;
    m_cap1 = 4'h0; m_cap2 = 4'h0; m_pend1 = 4'h0; m_pend2 = 4'h0;
    m_primed = 1'b0; ecount = 0; hist.delete();
  endtask

  task automatic model_edge(input logic [3:0] inp, input bit wr, input logic [1:0] a,
                            input logic [31:0] wd);
    logic [3:0] clr, s, nd;
    ecount++;
    hist.push_back(inp);
    clr = (wr && a == 2'd3) ? wd[3:0] : 4'h0;
    m_cap1 = (m_cap1 & ~clr) | m_pend1;
    m_cap2 = (m_cap2 & ~clr) | m_pend2;
    if (wr && a == 2'd2) m_mask = wd[3:0];
    m_pend1 = 4'h0;
    m_pend2 = 4'h0;
    if (ecount % 4 == 0) begin
      s = hist[ecount-3];
      if (!m_primed) begin
        m_deb = s;
        m_primed = 1'b1;
      end else begin
        nd = m_deb;
        for (int i = 0; i < 4; i++) if (s[i] == m_samp[i]) nd[i] = s[i];
        m_pend1 = m_deb & ~nd;
        m_pend2 = m_deb ^ nd;
        m_deb = nd;
      end
      m_samp = s;
    end
  endtask

  task automatic drive_bus(input bit wr, input logic [1:0] a, input logic [31:0] wd);
    bus1.chipselect = wr; bus1.write_n = !wr; bus1.address = a; bus1.writedata = wd;
    bus2.chipselect = wr; bus2.write_n = !wr; bus2.address = a; bus2.writedata = wd;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v1, output logic [31:0] v2);
    bus1.address = a;
    bus2.address = a;
    #1;
    v1 = bus1.readdata;
    v2 = bus2.readdata;
  endtask

  task automatic check_all();
    logic [31:0] v1, v2;
    drive_bus(1'b0, 2'd0, 32'h0);
    for (int a = 0; a < 4; a++) begin
      peek(2'(a), v1, v2);
      chk($sformatf("dut1_rd%0d", a), v1, m_read(2'(a), m_cap1));
      chk($sformatf("dut2_rd%0d", a), v2, m_read(2'(a), m_cap2));
    end
    chk("dut1_irq", {31'b0, irq1}, {31'b0, |(m_cap1 & m_mask)});
    chk("dut2_irq", {31'b0, irq2}, {31'b0, |(m_cap2 & m_mask)});
  endtask

  task automatic cyc(input logic [3:0] inp, input bit wr, input logic [1:0] a,
                     input logic [31:0] wd);
    keys = inp;
    drive_bus(wr, a, wd);
    @(posedge clk);
    model_edge(inp, wr, a, wd);
    #1;
    check_all();
  endtask

  task automatic idle(input logic [3:0] inp, input int n);
    for (int i = 0; i < n; i++) cyc(inp, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic do_reset(input logic [3:0] inp);
    logic [31:0] v1, v2;
    keys = inp;
    drive_bus(1'b0, 2'd0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    peek(2'd3, v1, v2);
    chk("rst_cap1", v1, 32'h0);
    chk("rst_cap2", v2, 32'h0);
    peek(2'd2, v1, v2);
    chk("rst_mask1", v1, 32'h0);
    chk("rst_mask2", v2, 32'h0);
    chk("rst_irq1", {31'b0, irq1}, 32'h0);
    chk("rst_irq2", {31'b0, irq2}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v1, v2;
    logic [3:0]  r;
    bit          found;
    reset_n = 1'b0;
    keys    = 4'hA;
    drive_bus(1'b0, 2'd0, 32'h0);
    model_reset();

    // Reset then priming with 1010 held throughout.
    do_reset(4'hA);
    idle(4'hA, 3);
    peek(2'd0, v1, v2);
    chk("prime_before", v1, 32'hF);
    idle(4'hA, 1);
    peek(2'd0, v1, v2);
    chk("prime_after", v1, 32'hA);
    peek(2'd3, v1, v2);
    chk("prime_cap", v1, 32'h0);
    chk("prime_irq", {31'b0, irq1}, 32'h0);

    // Debounced falling edge and interrupt, then write-1-to-clear.
    do_reset(4'hF);
    idle(4'hF, 4);
    cyc(4'hF, 1'b1, 2'd2, 32'h1);
    idle(4'hE, 12);
    peek(2'd0, v1, v2);
    chk("fall_data", v1, 32'hE);
    peek(2'd3, v1, v2);
    chk("fall_cap", v1, 32'h1);
    chk("fall_irq", {31'b0, irq1}, 32'h1);
    cyc(4'hE, 1'b1, 2'd3, 32'h1);
    peek(2'd3, v1, v2);
    chk("clr_cap", v1, 32'h0);
    chk("clr_irq", {31'b0, irq1}, 32'h0);

    // Glitch rejection: 3-cycle lows on bit1 at drifting phases.
    idle(4'hF, 12);
    cyc(4'hF, 1'b1, 2'd3, 32'hF);
    for (int p = 0; p < 8; p++) begin
      idle(4'hF, p % 4 + 6);
      idle(4'hD, 3);
    end
    idle(4'hF, 10);
    peek(2'd0, v1, v2);
    chk("glitch_data", v1, 32'hF);
    peek(2'd3, v1, v2);
    chk("glitch_cap", v1, 32'h0);

    // Clear/edge collision on bit2.
    idle(4'hB, 12);
    idle(4'hF, 12);
    peek(2'd3, v1, v2);
    chk("coll_pending", v1, 32'h4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_pend1[2]) begin
        cyc(4'hB, 1'b1, 2'd3, 32'h4);
        found = 1'b1;
      end else begin
        idle(4'hB, 1);
      end
    end
    peek(2'd3, v1, v2);
    chk("collision", v1, 32'h4);

    // Masking and ignored writes.
    cyc(4'hB, 1'b1, 2'd3, 32'hF);
    cyc(4'hB, 1'b1, 2'd2, 32'h0);
    idle(4'h3, 12);
    chk("mask_irq_off", {31'b0, irq1}, 32'h0);
    peek(2'd3, v1, v2);
    chk("mask_cap", v1, 32'h8);
    cyc(4'h3, 1'b1, 2'd2, 32'h8);
    chk("mask_irq_on", {31'b0, irq1}, 32'h1);
    cyc(4'h3, 1'b1, 2'd0, $urandom);
    cyc(4'h3, 1'b1, 2'd1, $urandom);
    cyc(4'h3, 1'b1, 2'd0, 32'hFFFF_FFFF);
    cyc(4'h3, 1'b1, 2'd1, 32'hFFFF_FFFF);

    // Any-edge instance: bit0 high->low->high.
    cyc(4'h3, 1'b1, 2'd3, 32'hF);
    idle(4'h2, 12);
    peek(2'd3, v1, v2);
    chk("any_fall", v2, 32'h1);
    cyc(4'h2, 1'b1, 2'd3, 32'h1);
    idle(4'h3, 12);
    peek(2'd3, v1, v2);
    chk("any_rise", v2, 32'h1);

    // Reset in the middle of a debounce with a pending unmasked capture.
    cyc(4'h3, 1'b1, 2'd2, 32'hF);
    chk("pre_reset_irq2", {31'b0, irq2}, 32'h1);
    idle(4'h0, 5);
    do_reset(4'h0);
    idle(4'h0, 6);
    peek(2'd3, v1, v2);
    chk("reprime_cap1", v1, 32'h0);
    chk("reprime_cap2", v2, 32'h0);

    // Randomized holds and register traffic.
    for (int it = 0; it < 40; it++) begin
      r = 4'($urandom);
      for (int j = 0; j < int'($urandom_range(1, 12)); j++) begin
        case ($urandom_range(0, 7))
          0:       cyc(r, 1'b1, 2'd2, $urandom);
          1:       cyc(r, 1'b1, 2'd3, $urandom);
          2:       cyc(r, 1'b1, 2'($urandom_range(0, 1)), $urandom);
          default: idle(r, 1);
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
